// File: rtl/ace_snoop_initiator.sv
// ACE snoop-channel initiator: issues a programmed burst of AC snoops, sinks CR/CD,
// and records per-snoop response latency plus protocol error flags.
module ace_snoop_initiator #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_ACE_DATA_WIDTH   = 128,
  parameter int C_ACE_ADDR_WIDTH   = 44,
  parameter int CD_BEATS           = 4
) (
  input  logic                          ace_aclk,
  input  logic                          ace_aresetn,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_control_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_acsnoop_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_base_addr_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_stride_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_timeout_reg,
  output logic                          o_acvalid,
  input  logic                          i_acready,
  output logic [C_ACE_ADDR_WIDTH-1:0]   o_acaddr,
  output logic [3:0]                    o_acsnoop,
  output logic [2:0]                    o_acprot,
  input  logic                          i_crvalid,
  output logic                          o_crready,
  input  logic [4:0]                    i_crresp,
  input  logic                          i_cdvalid,
  output logic                          o_cdready,
  input  logic [C_ACE_DATA_WIDTH-1:0]   i_cddata,
  input  logic                          i_cdlast,
  output logic [C_S_AXI_DATA_WIDTH-1:0] o_status_reg,
  output logic [4:0]                    o_last_crresp,
  output logic [31:0]                   o_last_latency,
  output logic [31:0]                   o_max_latency,
  output logic [C_ACE_DATA_WIDTH-1:0]   o_first_beat,
  output logic [3:0]                    o_fsm_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ISSUE     = 4'd1,
    S_WAIT_RESP = 4'd2,
    S_WAIT_CD   = 4'd3,
    S_NEXT      = 4'd4,
    S_DONE      = 4'd5
  } state_e;

  localparam logic [7:0] CD_BEATS_B = 8'(CD_BEATS);

  state_e                      state_q;
  logic [15:0]                 n_q;
  logic [15:0]                 count_q;
  logic [3:0]                  acsnoop_q;
  logic [2:0]                  acprot_q;
  logic [31:0]                 addr_q;
  logic [31:0]                 lat_q;
  logic [7:0]                  beats_q;
  logic                        data_done_q;
  logic                        done_q;
  logic [2:0]                  err_q;  // [0] timeout, [1] cdlast, [2] unexpected data
  logic                        acvalid_q;
  logic                        crready_q;
  logic                        cdready_q;
  logic [4:0]                  last_crresp_q;
  logic [31:0]                 last_lat_q;
  logic [31:0]                 max_lat_q;
  logic [C_ACE_DATA_WIDTH-1:0] first_beat_q;

  logic        en_s;
  logic [15:0] n_cfg_s;
  logic        cd_hs_s;
  logic        cr_hs_s;
  logic        timeout_hit_s;
  logic [7:0]  beats_inc_s;
  logic [7:0]  beats_now_s;
  logic        cd_err_s;
  logic        data_complete_s;
  logic [31:0] lat_inc_s;
  logic [15:0] count_inc_s;
  logic        unused_s;

  assign en_s            = i_control_reg[0];
  assign n_cfg_s         = i_control_reg[16:1];
  assign cd_hs_s         = i_cdvalid & cdready_q;
  assign cr_hs_s         = i_crvalid & crready_q;
  assign timeout_hit_s   = (i_timeout_reg != 32'd0) && (lat_q == i_timeout_reg);
  assign beats_inc_s     = (beats_q == 8'hFF) ? beats_q : beats_q + 8'd1;
  assign beats_now_s     = cd_hs_s ? beats_inc_s : beats_q;
  // A beat is in error if cdlast lands off the line boundary or data runs past it.
  assign cd_err_s        = cd_hs_s & ((i_cdlast & (beats_inc_s != CD_BEATS_B)) |
                                      (~i_cdlast & (beats_q >= CD_BEATS_B)));
  assign data_complete_s = data_done_q | (cd_hs_s & i_cdlast);
  assign lat_inc_s       = lat_q + 32'd1;
  assign count_inc_s     = count_q + 16'd1;
  assign unused_s        = ^{i_control_reg[31:17 + 3], i_acsnoop_reg[31:4]};

  // Snoop sequencer: control state, handshakes, latency and result capture.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      state_q       <= S_IDLE;
      n_q           <= 16'd0;
      count_q       <= 16'd0;
      acsnoop_q     <= 4'd0;
      acprot_q      <= 3'd0;
      addr_q        <= 32'd0;
      lat_q         <= 32'd0;
      beats_q       <= 8'd0;
      data_done_q   <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 3'd0;
      acvalid_q     <= 1'b0;
      crready_q     <= 1'b0;
      cdready_q     <= 1'b0;
      last_crresp_q <= 5'd0;
      last_lat_q    <= 32'd0;
      max_lat_q     <= 32'd0;
      first_beat_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!en_s) begin
            done_q <= 1'b0;
            err_q  <= 3'd0;
          end else if (!done_q) begin
            n_q       <= n_cfg_s;
            acsnoop_q <= i_acsnoop_reg[3:0];
            acprot_q  <= i_control_reg[19:17];
            addr_q    <= i_base_addr_reg;
            count_q   <= 16'd0;
            err_q     <= 3'd0;
            max_lat_q <= 32'd0;
            if (n_cfg_s == 16'd0) begin
              state_q <= S_DONE;
            end else begin
              state_q   <= S_ISSUE;
              acvalid_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (acvalid_q && i_acready) begin
            acvalid_q   <= 1'b0;
            lat_q       <= 32'd0;
            beats_q     <= 8'd0;
            data_done_q <= 1'b0;
            crready_q   <= 1'b1;
            cdready_q   <= 1'b1;
            state_q     <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP, S_WAIT_CD: begin
          // Timeout wins over any handshake presented in the same cycle.
          if (timeout_hit_s) begin
            err_q[0]  <= 1'b1;
            crready_q <= 1'b0;
            cdready_q <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            lat_q <= lat_inc_s;
            if (cd_hs_s) begin
              beats_q <= beats_inc_s;
              if (beats_q == 8'd0) begin
                first_beat_q <= i_cddata;
              end
              if (i_cdlast) begin
                data_done_q <= 1'b1;
              end
              if (cd_err_s) begin
                err_q[1] <= 1'b1;
              end
            end
            if (state_q == S_WAIT_CD) begin
              if (cd_hs_s && i_cdlast) begin
                cdready_q <= 1'b0;
                state_q   <= S_NEXT;
              end
            end else if (cr_hs_s) begin
              last_crresp_q <= i_crresp;
              last_lat_q    <= lat_inc_s;
              if (lat_inc_s > max_lat_q) begin
                max_lat_q <= lat_inc_s;
              end
              crready_q <= 1'b0;
              if (i_crresp[0] && !data_complete_s) begin
                state_q <= S_WAIT_CD;
              end else begin
                if (!i_crresp[0] && (beats_now_s != 8'd0)) begin
                  err_q[2] <= 1'b1;
                end
                cdready_q <= 1'b0;
                state_q   <= S_NEXT;
              end
            end
          end
        end
        S_NEXT: begin
          count_q <= count_inc_s;
          addr_q  <= addr_q + i_stride_reg;
          if (count_inc_s == n_q) begin
            state_q <= S_DONE;
          end else begin
            state_q   <= S_ISSUE;
            acvalid_q <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          acvalid_q <= 1'b0;
          crready_q <= 1'b0;
          cdready_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign o_acvalid      = acvalid_q;
  assign o_acaddr       = {{(C_ACE_ADDR_WIDTH-32){1'b0}}, addr_q};
  assign o_acsnoop      = acsnoop_q;
  assign o_acprot       = acprot_q;
  assign o_crready      = crready_q;
  assign o_cdready      = cdready_q;
  assign o_status_reg   = {count_q, 11'd0, (state_q != S_IDLE), err_q, done_q};
  assign o_last_crresp  = last_crresp_q;
  assign o_last_latency = last_lat_q;
  assign o_max_latency  = max_lat_q;
  assign o_first_beat   = first_beat_q;
  assign o_fsm_state    = state_q;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Directed bench for ace_snoop_initiator: a scripted snoop responder drives CR/CD
// and results are compared against hand-computed values.
module tb_ace_snoop_initiator;

  localparam int DW = 128;
  localparam int AW = 44;

  logic          ace_aclk = 1'b0;
  logic          ace_aresetn = 1'b0;
  logic [31:0]   i_control_reg = 32'd0;
  logic [31:0]   i_acsnoop_reg = 32'd0;
  logic [31:0]   i_base_addr_reg = 32'd0;
  logic [31:0]   i_stride_reg = 32'd0;
  logic [31:0]   i_timeout_reg = 32'd0;
  logic          o_acvalid;
  logic          i_acready = 1'b0;
  logic [AW-1:0] o_acaddr;
  logic [3:0]    o_acsnoop;
  logic [2:0]    o_acprot;
  logic          i_crvalid = 1'b0;
  logic          o_crready;
  logic [4:0]    i_crresp = 5'd0;
  logic          i_cdvalid = 1'b0;
  logic          o_cdready;
  logic [DW-1:0] i_cddata = '0;
  logic          i_cdlast = 1'b0;
  logic [31:0]   o_status_reg;
  logic [4:0]    o_last_crresp;
  logic [31:0]   o_last_latency;
  logic [31:0]   o_max_latency;
  logic [DW-1:0] o_first_beat;
  logic [3:0]    o_fsm_state;

  int errors = 0;
  int checks = 0;
  int ac_hs_cnt = 0;

  ace_snoop_initiator dut (
    .ace_aclk        (ace_aclk),
    .ace_aresetn     (ace_aresetn),
    .i_control_reg   (i_control_reg),
    .i_acsnoop_reg   (i_acsnoop_reg),
    .i_base_addr_reg (i_base_addr_reg),
    .i_stride_reg    (i_stride_reg),
    .i_timeout_reg   (i_timeout_reg),
    .o_acvalid       (o_acvalid),
    .i_acready       (i_acready),
    .o_acaddr        (o_acaddr),
    .o_acsnoop       (o_acsnoop),
    .o_acprot        (o_acprot),
    .i_crvalid       (i_crvalid),
    .o_crready       (o_crready),
    .i_crresp        (i_crresp),
    .i_cdvalid       (i_cdvalid),
    .o_cdready       (o_cdready),
    .i_cddata        (i_cddata),
    .i_cdlast        (i_cdlast),
    .o_status_reg    (o_status_reg),
    .o_last_crresp   (o_last_crresp),
    .o_last_latency  (o_last_latency),
    .o_max_latency   (o_max_latency),
    .o_first_beat    (o_first_beat),
    .o_fsm_state     (o_fsm_state)
  );

  always #5 ace_aclk = ~ace_aclk;

  // Count AC handshakes seen by the responder.
  always @(posedge ace_aclk) begin
    if (ace_aresetn && o_acvalid && i_acready) ac_hs_cnt <= ac_hs_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int s, input int b);
    return {32'hC0DE_0000 + 32'(s), 32'(b), 64'hA5A5_5A5A_0F0F_F0F0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge ace_aclk);
  endtask

  task automatic configure(input logic [31:0] ctrl, input logic [31:0] base, input logic [31:0] tmo);
    i_control_reg = 32'd0;
    cyc(2);
    i_acsnoop_reg   = 32'h1;
    i_base_addr_reg = base;
    i_stride_reg    = 32'h40;
    i_timeout_reg   = tmo;
    i_control_reg   = ctrl;
  endtask

  task automatic wait_acvalid(input string tag);
    int k = 0;
    while (!o_acvalid && k < 20) begin
      cyc(1);
      k++;
    end
    if (!o_acvalid) check_eq({tag, "_acvalid_wait"}, 128'(o_acvalid), 128'd1);
  endtask

  task automatic ac_handshake(input string tag, input logic [31:0] exp_addr);
    wait_acvalid(tag);
    check_eq({tag, "_acaddr"}, 128'(o_acaddr), 128'(exp_addr));
    i_acready = 1'b1;
    cyc(1);
    i_acready = 1'b0;
  endtask

  // Called on the first negedge after the AC handshake; CR handshake lands delay edges later.
  task automatic send_cr(input int delay, input logic [4:0] resp);
    cyc(delay - 1);
    i_crvalid = 1'b1;
    i_crresp  = resp;
    cyc(1);
    i_crvalid = 1'b0;
    i_crresp  = 5'd0;
  endtask

  task automatic send_beats(input int n, input bit last_on_final, input int s);
    for (int b = 0; b < n; b++) begin
      i_cdvalid = 1'b1;
      i_cddata  = beat_data(s, b);
      i_cdlast  = last_on_final && (b == n - 1);
      cyc(1);
    end
    i_cdvalid = 1'b0;
    i_cdlast  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!o_status_reg[0] && k < 60) begin
      cyc(1);
      k++;
    end
    if (!o_status_reg[0]) check_eq({tag, "_done_wait"}, 128'(o_status_reg[0]), 128'd1);
  endtask

  initial begin
    int snap;
    bit stable;

    // Reset state
    cyc(3);
    check_eq("rst_status", 128'(o_status_reg), 128'd0);
    check_eq("rst_acvalid", 128'(o_acvalid), 128'd0);
    check_eq("rst_readies", 128'({o_crready, o_cdready}), 128'd0);
    check_eq("rst_state", 128'(o_fsm_state), 128'd0);
    ace_aresetn = 1'b1;
    cyc(2);

    // Single snoop, CR 3 cycles after the AC handshake
    snap = ac_hs_cnt;
    configure(32'h0004_0003, 32'h1000, 32'd0);
    wait_acvalid("t1");
    check_eq("t1_snoop_prot", 128'({o_acsnoop, o_acprot}), 128'({4'h1, 3'd2}));
    ac_handshake("t1", 32'h1000);
    send_cr(3, 5'h00);
    wait_done("t1");
    cyc(4);
    check_eq("t1_status", 128'(o_status_reg), 128'h0001_0001);
    check_eq("t1_last_lat", 128'(o_last_latency), 128'd3);
    check_eq("t1_ac_count", 128'(ac_hs_cnt - snap), 128'd1);
    i_control_reg = 32'd0;
    cyc(2);
    check_eq("t1_en_drop", 128'(o_status_reg), 128'h0001_0000);

    // Four snoops with data, CR before CD, latencies 4,3,2,1
    snap = ac_hs_cnt;
    configure(32'h0000_0009, 32'h1000, 32'd0);
    for (int s = 0; s < 4; s++) begin
      ac_handshake($sformatf("t2_s%0d", s), 32'h1000 + 32'(s) * 32'h40);
      send_cr(4 - s, 5'h01);
      send_beats(4, 1'b1, s);
    end
    wait_done("t2");
    check_eq("t2_status", 128'(o_status_reg), 128'h0004_0001);
    check_eq("t2_first_beat", 128'(o_first_beat), beat_data(3, 0));
    check_eq("t2_last_lat", 128'(o_last_latency), 128'd1);
    check_eq("t2_max_lat", 128'(o_max_latency), 128'd4);
    check_eq("t2_last_crresp", 128'(o_last_crresp), 128'h01);
    check_eq("t2_ac_count", 128'(ac_hs_cnt - snap), 128'd4);

    // CD data complete before CR: WAIT_CD skipped
    configure(32'h0000_0003, 32'h1000, 32'd0);
    ac_handshake("t3", 32'h1000);
    send_beats(4, 1'b1, 7);
    send_cr(1, 5'h01);
    check_eq("t3_state_next", 128'(o_fsm_state), 128'd4);
    wait_done("t3");
    check_eq("t3_status", 128'(o_status_reg), 128'h0001_0001);
    check_eq("t3_last_lat", 128'(o_last_latency), 128'd5);
    check_eq("t3_first_beat", 128'(o_first_beat), beat_data(7, 0));

    // cdlast on beat 2 of 4
    configure(32'h0000_0003, 32'h1000, 32'd0);
    ac_handshake("t4a", 32'h1000);
    send_cr(1, 5'h01);
    send_beats(2, 1'b1, 5);
    wait_done("t4a");
    check_eq("t4a_status", 128'(o_status_reg), 128'h0001_0005);

    // Data beat with crresp[0]=0
    configure(32'h0000_0003, 32'h1000, 32'd0);
    ac_handshake("t4b", 32'h1000);
    send_beats(1, 1'b0, 6);
    send_cr(1, 5'h00);
    wait_done("t4b");
    check_eq("t4b_status", 128'(o_status_reg), 128'h0001_0009);
    check_eq("t4b_last_lat", 128'(o_last_latency), 128'd2);

    // Timeout 200 with no CR: flag rises on the edge after lat reaches 200
    configure(32'h0000_0003, 32'h1000, 32'd200);
    ac_handshake("t5", 32'h1000);
    cyc(200);
    check_eq("t5_pre_timeout", 128'({o_status_reg[1], o_crready}), 128'({1'b0, 1'b1}));
    cyc(1);
    check_eq("t5_timeout", 128'({o_status_reg[1], o_crready, o_cdready}), 128'({1'b1, 1'b0, 1'b0}));
    check_eq("t5_state_done", 128'(o_fsm_state), 128'd5);
    wait_done("t5");
    check_eq("t5_status", 128'(o_status_reg), 128'h0000_0003);

    // N=0: done with no AC traffic
    snap = ac_hs_cnt;
    configure(32'h0000_0001, 32'h1000, 32'd0);
    cyc(6);
    check_eq("t7_status", 128'(o_status_reg), 128'h0000_0001);
    check_eq("t7_ac_count", 128'(ac_hs_cnt - snap), 128'd0);

    // acready low for 50 cycles (en dropped midway), then reset mid-ISSUE
    configure(32'h0000_0005, 32'h2000, 32'd0);
    wait_acvalid("t6");
    check_eq("t6_busy", 128'(o_status_reg), 128'h0000_0010);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) i_control_reg = 32'd0;
      if (!o_acvalid || o_acaddr != 44'h2000) stable = 1'b0;
      cyc(1);
    end
    check_eq("t6_ac_stable", 128'(stable), 128'd1);
    #2 ace_aresetn = 1'b0;
    #1;
    check_eq("t6_rst_acvalid", 128'(o_acvalid), 128'd0);
    check_eq("t6_rst_status", 128'(o_status_reg), 128'd0);
    check_eq("t6_rst_regs", 128'({o_last_latency, o_max_latency, o_fsm_state, o_last_crresp}), 128'd0);
    check_eq("t6_rst_addr_beat", 128'(o_acaddr) | 128'(o_first_beat), 128'd0);
    cyc(2);
    ace_aresetn = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
